elevator_call_panel: RTL
========================

Name: elevator_call_panel

Overview:
Front end for the elevator controller's request interface. It takes raw car-panel and hall-panel push buttons, synchronises and debounces each one, and latches every press into a lamp register. It drives the level-type request vectors `buttons`, `ups` and `downs` into the controller. It also watches the controller's `up`, `down`, `open` and `floor` outputs, and clears lamps and requests once the car has serviced a floor.

Parameters:
- floor_numbers, 10, number of floors; also the width of every per-floor vector.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before the debounced level changes; legal range ≥ 2.
- STUCK_CYCLES, 1024, held-pressed cycles before a button is declared stuck; used only with STUCK_BUTTON_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- raw_car  in  floor_numbers  car-panel buttons, asynchronous, 1 = pressed.
- raw_up  in  floor_numbers  hall up buttons, asynchronous.
- raw_down  in  floor_numbers  hall down buttons, asynchronous.
- up  in  1  controller moving-up indication.
- down  in  1  controller moving-down indication.
- open  in  1  controller door-open indication.
- floor  in  4  controller current floor.
- buttons  out  floor_numbers  internal (car) requests to the controller.
- ups  out  floor_numbers  hall up requests to the controller.
- downs  out  floor_numbers  hall down requests to the controller.
- car_lamps  out  floor_numbers  car-button lamps.
- up_lamps  out  floor_numbers  hall up lamps.
- down_lamps  out  floor_numbers  hall down lamps.
- stuck_flags  out  3*floor_numbers  present only with STUCK_BUTTON_EN; order is {down, up, car}.

Behaviour:
- **Reset.** Reset is asynchronous and active-high. It clears all synchronisers, debounce counters, debounced levels, lamps, last_dir (set to up) and stuck flags. All outputs are 0 while reset is asserted. Assertion mid-operation drops every pending lamp and request immediately.
- **Synchronisers.** Each raw input passes through a 2-flop synchroniser.
- **Debounce, per input.**
  - The counter increments on every cycle where the synchronised value differs from the debounced level.
  - A cycle where they agree resets the counter to 0.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level toggles at the next edge and the counter returns to 0.
- **Press detection.** A press is a rising edge of the debounced level, detected with one register stage.
- **Latency.** A clean press sets its lamp exactly 3+DEBOUNCE_CYCLES rising edges after the raw input is first high at a sampling edge. With the default of 4, this is 7 edges.
- **Floor masks.**
  - raw_up[floor_numbers-1] and raw_down[0] are ignored.
  - Their lamps and outputs are constant 0.
- **Direction tracking.**
  - last_dir is a 1-bit register.
  - up=1 sets it to UP; down=1 sets it to DOWN. If both are 1, last_dir holds.
- **Service clear.** In each cycle where open=1 and floor < floor_numbers, with f = floor:
  - car_lamps[f] clears.
  - If last_dir=UP: up_lamps[f] clears. down_lamps[f] also clears, but only if up_lamps[f] was 0 that cycle.
  - If last_dir=DOWN: the same rule applies with up and down swapped.
- **Out-of-range floor.** When floor ≥ floor_numbers, no lamp is cleared.
- **Simultaneous press and service clear on the same bit.** The clear wins and the press is discarded; a fresh press edge is needed afterwards. Presses on other bits are latched normally.
- **Request outputs.**
  - buttons = car_lamps, ups = up_lamps, downs = down_lamps.
  - All three are registered lamp state, with no combinational path from the raw inputs.
  - They remain asserted until serviced, so a request issued while the controller is in door-open is re-presented once `open` falls.

Optional Feature:
Macro STUCK_BUTTON_EN.
- **Defined.**
  - A per-input hold counter, saturating at STUCK_CYCLES, counts cycles with the debounced level at 1.
  - On reaching STUCK_CYCLES, that input's stuck flag sets. Its lamp is cleared and forced to 0, and further presses on it are ignored.
  - A flag clears only when the debounced level returns to 0 for DEBOUNCE_CYCLES cycles, or on reset.
  - The stuck_flags port exists.
- **Undefined.** No hold counters, no stuck_flags port, and presses are never masked.

Decomposition:
- Package elevator_pkg holds:
  - FLOOR_W = 4;
  - the dir_t enum {DIR_UP, DIR_DOWN};
  - the MAX_FLOORS = 16 constant.
- Sub-module elevator_debounce is instantiated 3*floor_numbers times. It covers the 2-flop synchroniser, debounce counter, debounced level and rise pulse, plus the hold counter when STUCK_BUTTON_EN is defined.
- The top level holds the lamps, last_dir, the clear logic and the floor masks.

Test Plan:
1. **Clean press latency.** Defaults; raw_car[5] goes high at edge 0 and is held → car_lamps[5] and buttons[5] rise at edge 7 and stay high with open=0.
2. **Bounce rejection.** raw_up[2] toggles every 2 cycles for 20 cycles, then settles low → up_lamps stays 0x000 throughout.
3. **Direction-aware clear.** up_lamps[4]=down_lamps[4]=1; pulse up=1, then open=1 with floor=4 for 1 cycle → up_lamps[4]=0, down_lamps[4]=1, downs[4]=1.
4. **Edge floors and out-of-range floor.** Clean presses on raw_up[9] and raw_down[0] → ups/downs stay 0x000. With open=1 and floor=12, and car_lamps=0x3FF → no lamp changes.
5. **Press during service, then reset.** Press raw_car[3] so its edge lands while open=1 and floor=3 → discarded and car_lamps[3]=0. Press again after open falls → lamp sets. Assert reset mid-debounce → all outputs 0 asynchronously, and no lamp appears after release.
6. **Stuck button (STUCK_BUTTON_EN, STUCK_CYCLES=32).** Hold raw_car[1] high → lamp sets at edge 7; stuck_flags[1] sets once 32 held cycles have elapsed, and car_lamps[1] is forced to 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call panel.
// Optional feature macro used by this slice: STUCK_BUTTON_EN.
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // A lone up or down indication sets the direction.
    // Both at once, or neither, keeps the previous direction.
    function automatic dir_t next_dir(input dir_t cur, input logic up_i, input logic down_i);
        dir_t res;
        if (up_i && !down_i) begin
            res = DIR_UP;
        end else if (down_i && !up_i) begin
            res = DIR_DOWN;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/elevator_debounce.sv
// One push-button input: 2-flop synchroniser, debounce counter, debounced level
// and a registered rise pulse. With STUCK_BUTTON_EN defined it also has a
// hold counter and a stuck flag.
module elevator_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise
`ifdef STUCK_BUTTON_EN
    ,
    output logic stuck
`endif
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             rise_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Toggle the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync_r[1] != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Register a one-cycle pulse on each rising edge of the debounced level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            level_d_r <= level_r;
            rise_r    <= level_r & ~level_d_r;
        end
    end

    assign rise = rise_r;

`ifdef STUCK_BUTTON_EN
    localparam int               HOLD_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_SET = HOLD_W'(STUCK_CYCLES - 1);

    logic [HOLD_W-1:0] hold_r;
    logic [CNT_W-1:0]  low_r;
    logic              stuck_r;

    // Count held-pressed cycles and set the stuck flag; clear it after DEBOUNCE_CYCLES released cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_r  <= {HOLD_W{1'b0}};
            low_r   <= {CNT_W{1'b0}};
            stuck_r <= 1'b0;
        end else if (level_r) begin
            low_r <= {CNT_W{1'b0}};
            if (hold_r != HOLD_MAX) begin
                hold_r <= hold_r + HOLD_W'(1);
            end else begin
                hold_r <= hold_r;
            end
            if (hold_r == HOLD_SET) begin
                stuck_r <= 1'b1;
            end else begin
                stuck_r <= stuck_r;
            end
        end else begin
            hold_r <= {HOLD_W{1'b0}};
            if (low_r == CNT_LAST) begin
                stuck_r <= 1'b0;
                low_r   <= low_r;
            end else begin
                low_r   <= low_r + CNT_W'(1);
            end
        end
    end

    assign stuck = stuck_r;
`endif

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel front end: debounces car and hall buttons, latches presses into
// lamps, presents the lamps as request vectors and clears them as floors are
// serviced. Optional feature macro: STUCK_BUTTON_EN (adds stuck detection and
// the stuck_flags port).
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int floor_numbers   = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [floor_numbers-1:0] raw_car,
    input  logic [floor_numbers-1:0] raw_up,
    input  logic [floor_numbers-1:0] raw_down,
    input  logic                     up,
    input  logic                     down,
    input  logic                     open,
    input  logic [FLOOR_W-1:0]       floor,
    output logic [floor_numbers-1:0] buttons,
    output logic [floor_numbers-1:0] ups,
    output logic [floor_numbers-1:0] downs,
    output logic [floor_numbers-1:0] car_lamps,
    output logic [floor_numbers-1:0] up_lamps,
    output logic [floor_numbers-1:0] down_lamps
`ifdef STUCK_BUTTON_EN
    ,
    output logic [3*floor_numbers-1:0] stuck_flags
`endif
);

    // No up call from the top floor, no down call from the ground floor.
    localparam logic [floor_numbers-1:0] UP_MASK   = {floor_numbers{1'b1}} >> 1;
    localparam logic [floor_numbers-1:0] DOWN_MASK = {floor_numbers{1'b1}} << 1;

    logic [floor_numbers-1:0] car_rise_s, up_rise_s, down_rise_s;
    logic [floor_numbers-1:0] car_blk_s, up_blk_s, down_blk_s;
    logic [floor_numbers-1:0] svc_s;
    logic [floor_numbers-1:0] car_clr_s, up_clr_s, down_clr_s;
    logic [floor_numbers-1:0] car_next_s, up_next_s, down_next_s;
    logic [floor_numbers-1:0] car_lamps_r, up_lamps_r, down_lamps_r;
    dir_t                     last_dir_r;

`ifdef STUCK_BUTTON_EN
    logic [floor_numbers-1:0] car_stuck_s, up_stuck_s, down_stuck_s;
`endif

    for (genvar i = 0; i < floor_numbers; i++) begin : g_btn
        elevator_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_car (
            .clock(clock),
            .reset(reset),
            .raw  (raw_car[i]),
            .rise (car_rise_s[i])
`ifdef STUCK_BUTTON_EN
            ,
            .stuck(car_stuck_s[i])
`endif
        );

        elevator_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_up (
            .clock(clock),
            .reset(reset),
            .raw  (raw_up[i]),
            .rise (up_rise_s[i])
`ifdef STUCK_BUTTON_EN
            ,
            .stuck(up_stuck_s[i])
`endif
        );

        elevator_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_down (
            .clock(clock),
            .reset(reset),
            .raw  (raw_down[i]),
            .rise (down_rise_s[i])
`ifdef STUCK_BUTTON_EN
            ,
            .stuck(down_stuck_s[i])
`endif
        );
    end

`ifdef STUCK_BUTTON_EN
    assign car_blk_s   = car_stuck_s;
    assign up_blk_s    = up_stuck_s;
    assign down_blk_s  = down_stuck_s;
    assign stuck_flags = {down_stuck_s, up_stuck_s, car_stuck_s};
`else
    assign car_blk_s   = {floor_numbers{1'b0}};
    assign up_blk_s    = {floor_numbers{1'b0}};
    assign down_blk_s  = {floor_numbers{1'b0}};
`endif

    // Decode the floor being serviced; an out-of-range floor selects nothing.
    always_comb begin
        svc_s = {floor_numbers{1'b0}};
        for (int i = 0; i < floor_numbers; i++) begin
            if (open && (floor == FLOOR_W'(i))) begin
                svc_s[i] = 1'b1;
            end else begin
                svc_s[i] = 1'b0;
            end
        end
    end

    // Travel-direction hall lamp always clears; the opposite one only if no same-direction call was lit.
    always_comb begin
        car_clr_s = svc_s;
        if (last_dir_r == DIR_UP) begin
            up_clr_s   = svc_s;
            down_clr_s = svc_s & ~up_lamps_r;
        end else begin
            down_clr_s = svc_s;
            up_clr_s   = svc_s & ~down_lamps_r;
        end
    end

    // Next lamp state: clear and stuck beat a coincident press; masked floors stay dark.
    always_comb begin
        car_next_s  = (car_lamps_r  | car_rise_s)  & ~car_clr_s  & ~car_blk_s;
        up_next_s   = (up_lamps_r   | up_rise_s)   & ~up_clr_s   & ~up_blk_s   & UP_MASK;
        down_next_s = (down_lamps_r | down_rise_s) & ~down_clr_s & ~down_blk_s & DOWN_MASK;
    end

    // Lamp registers, which double as the request vectors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            car_lamps_r  <= {floor_numbers{1'b0}};
            up_lamps_r   <= {floor_numbers{1'b0}};
            down_lamps_r <= {floor_numbers{1'b0}};
        end else begin
            car_lamps_r  <= car_next_s;
            up_lamps_r   <= up_next_s;
            down_lamps_r <= down_next_s;
        end
    end

    // Remember the last travel direction reported by the controller.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dir_r <= DIR_UP;
        end else begin
            last_dir_r <= next_dir(last_dir_r, up, down);
        end
    end

    assign car_lamps  = car_lamps_r;
    assign up_lamps   = up_lamps_r;
    assign down_lamps = down_lamps_r;
    assign buttons    = car_lamps_r;
    assign ups        = up_lamps_r;
    assign downs      = down_lamps_r;

endmodule
